cpu_fpu_issue: RTL and testbench
================================

Name: cpu_fpu_issue

Overview:
- Issue/retire stage directly upstream of CPU_FPU.
- Accepts one FP operation from the execute stage over a valid/ready handshake and latches opcode, operands and destination tag.
- Holds i_request to CPU_FPU until its o_ready is seen, registers the result, and presents it to writeback over a valid/ready handshake.
- Guarantees the request-level protocol CPU_FPU sub-units rely on: request held stable while busy, and dropped for at least one cycle between operations.

Parameters:
- TAG_W, 5, width of destination register tag carried alongside the operation.
- TIMEOUT, 255, watchdog limit in cycles (used only with CPU_FPU_ISSUE_TIMEOUT_EN).

Ports:
- i_clock  in  1  clock, all state updates on rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- i_valid  in  1  upstream operation valid.
- o_ready  out  1  stage can accept an operation this cycle.
- i_op  in  5  FPU_OP_* opcode.
- i_op1, i_op2, i_op3  in  32 each  operands.
- i_rd  in  TAG_W  destination tag.
- i_int_dst  in  1  result goes to the integer register file (F2I, CMP_*).
- i_flush  in  1  abandon any in-flight or held operation.
- o_fpu_request  out  1  to CPU_FPU i_request.
- o_fpu_op  out  5  to CPU_FPU i_op.
- o_fpu_op1, o_fpu_op2, o_fpu_op3  out  32 each  to CPU_FPU operands.
- i_fpu_ready  in  1  from CPU_FPU o_ready.
- i_fpu_result  in  32  from CPU_FPU o_result.
- o_valid  out  1  result valid to writeback.
- i_wb_ready  in  1  writeback accepts result.
- o_result  out  32  registered result.
- o_rd  out  TAG_W  registered tag.
- o_int_dst  out  1  registered destination-file select.
- o_error  out  1  result produced by watchdog abort (0 when feature is off).

Behaviour:
- Reset (i_reset=0 at edge):
  - State goes to IDLE.
  - o_fpu_request, o_valid and o_error are 0.
  - o_result, o_rd, o_int_dst and the latched op/operands are 0.
  - Reset has priority over every other input, including mid-BUSY; the request drops the next cycle.
- States:
  - IDLE: o_ready=1, o_fpu_request=0. On i_valid and not i_flush, latch op/operands/rd/int_dst and go to BUSY.
  - BUSY: o_ready=0, o_fpu_request=1, op/operands stable. On i_fpu_ready, register i_fpu_result, rd and int_dst, then go to DONE.
  - DONE: o_valid=1, o_fpu_request=0. On i_wb_ready go to IDLE. Otherwise hold; result, rd and int_dst stay stable.
- Latency:
  - Accept at edge T; request is high from T.
  - If the FPU reports ready in cycle T+L (L≥0 cycles after the request rises), o_valid rises at the following edge.
  - MOV and SGNJ* (combinationally ready): o_valid is 2 cycles after acceptance.
- The FPU sees request low for ≥2 cycles between operations (DONE + IDLE). Back-to-back throughput is one op per L+3 cycles minimum.
- i_fpu_ready is ignored outside BUSY.
- Flush:
  - In BUSY or DONE, i_flush → IDLE next cycle, with no o_valid and the request dropped.
  - In IDLE, flush suppresses acceptance that cycle.
  - Flush coincident with i_fpu_ready in BUSY: the flush wins and the result is discarded.
  - Flush coincident with i_wb_ready in DONE: the handshake completes (the result was consumed); go to IDLE.
- o_ready is a pure function of state, with no combinational path from i_valid.

Optional Feature:
- CPU_FPU_ISSUE_TIMEOUT_EN defined:
  - An 8-bit cycle counter clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without i_fpu_ready, go to DONE with o_result=32'h7FC00000 (canonical NaN) and o_error=1.
  - o_error clears when DONE is left.
- Undefined: no counter, o_error tied 0, and BUSY waits indefinitely.

Decomposition:
- Shared package (alongside CPU_Defines): FPU_OP_* opcode constants, the issue state enum (IDLE/BUSY/DONE), and the canonical NaN constant.
- One natural sub-module: cpu_fpu_issue_watchdog (counter + compare), instantiated only under CPU_FPU_ISSUE_TIMEOUT_EN.
- All other logic stays flat.

Test Plan:
- Bench uses a CPU_FPU stub with programmable latency.
- FADD, op1=32'h3F800000, op2=32'h40000000, rd=7, stub latency 4 → o_valid exactly 6 cycles after accept, o_result=32'h40400000, o_rd=7, request high exactly 5 cycles.
- MOV at latency 0, then a second op issued the instant o_ready returns → o_valid 2 cycles after accept; request low ≥2 cycles between ops.
- i_wb_ready held 0 for 10 cycles in DONE → o_valid, o_result and o_rd stable for all 10 cycles; o_ready=0 and request=0 throughout.
- i_flush asserted in the same cycle as i_fpu_ready → no o_valid ever for that op; IDLE next cycle.
- Reset asserted low mid-BUSY → o_fpu_request=0 and o_valid=0 the next cycle; a later op completes normally.
- With CPU_FPU_ISSUE_TIMEOUT_EN and TIMEOUT=16, stub never ready → o_valid after 16 BUSY cycles, o_result=32'h7FC00000, o_error=1.

Source files
------------

// File: rtl/cpu_fpu_issue_pkg.sv
// cpu_fpu_issue shared definitions: FPU opcodes, issue FSM states, canonical NaN.
// Used by cpu_fpu_issue and its watchdog (CPU_FPU_ISSUE_TIMEOUT_EN).
package cpu_fpu_issue_pkg;

  localparam logic [4:0] FPU_OP_FADD   = 5'd0;
  localparam logic [4:0] FPU_OP_FSUB   = 5'd1;
  localparam logic [4:0] FPU_OP_FMUL   = 5'd2;
  localparam logic [4:0] FPU_OP_FDIV   = 5'd3;
  localparam logic [4:0] FPU_OP_FSQRT  = 5'd4;
  localparam logic [4:0] FPU_OP_FMADD  = 5'd5;
  localparam logic [4:0] FPU_OP_FMSUB  = 5'd6;
  localparam logic [4:0] FPU_OP_FNMADD = 5'd7;
  localparam logic [4:0] FPU_OP_FNMSUB = 5'd8;
  localparam logic [4:0] FPU_OP_SGNJ   = 5'd9;
  localparam logic [4:0] FPU_OP_SGNJN  = 5'd10;
  localparam logic [4:0] FPU_OP_SGNJX  = 5'd11;
  localparam logic [4:0] FPU_OP_MIN    = 5'd12;
  localparam logic [4:0] FPU_OP_MAX    = 5'd13;
  localparam logic [4:0] FPU_OP_CMP_EQ = 5'd14;
  localparam logic [4:0] FPU_OP_CMP_LT = 5'd15;
  localparam logic [4:0] FPU_OP_CMP_LE = 5'd16;
  localparam logic [4:0] FPU_OP_F2I    = 5'd17;
  localparam logic [4:0] FPU_OP_F2U    = 5'd18;
  localparam logic [4:0] FPU_OP_I2F    = 5'd19;
  localparam logic [4:0] FPU_OP_U2F    = 5'd20;
  localparam logic [4:0] FPU_OP_MOV    = 5'd21;
  localparam logic [4:0] FPU_OP_CLASS  = 5'd22;

  localparam logic [31:0] FPU_CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } issue_st_e;

endpackage

// File: rtl/cpu_fpu_issue_if.sv
// cpu_fpu_issue bus bundle: execute-side, CPU_FPU-side and writeback-side signals.
// slave = the issue stage, master = its surroundings.
interface cpu_fpu_issue_if #(
  parameter int TAG_W = 5
);
  logic             i_valid;
  logic             o_ready;
  logic [4:0]       i_op;
  logic [31:0]      i_op1;
  logic [31:0]      i_op2;
  logic [31:0]      i_op3;
  logic [TAG_W-1:0] i_rd;
  logic             i_int_dst;
  logic             i_flush;
  logic             o_fpu_request;
  logic [4:0]       o_fpu_op;
  logic [31:0]      o_fpu_op1;
  logic [31:0]      o_fpu_op2;
  logic [31:0]      o_fpu_op3;
  logic             i_fpu_ready;
  logic [31:0]      i_fpu_result;
  logic             o_valid;
  logic             i_wb_ready;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_rd;
  logic             o_int_dst;
  logic             o_error;

  modport slave (
    input  i_valid, i_op, i_op1, i_op2, i_op3,
    input  i_rd, i_int_dst, i_flush,
    input  i_fpu_ready, i_fpu_result, i_wb_ready,
    output o_ready, o_fpu_request, o_fpu_op,
    output o_fpu_op1, o_fpu_op2, o_fpu_op3,
    output o_valid, o_result, o_rd, o_int_dst, o_error
  );

  modport master (
    output i_valid, i_op, i_op1, i_op2, i_op3,
    output i_rd, i_int_dst, i_flush,
    output i_fpu_ready, i_fpu_result, i_wb_ready,
    input  o_ready, o_fpu_request, o_fpu_op,
    input  o_fpu_op1, o_fpu_op2, o_fpu_op3,
    input  o_valid, o_result, o_rd, o_int_dst, o_error
  );
endinterface

// File: rtl/cpu_fpu_issue_watchdog.sv
// BUSY-cycle watchdog for cpu_fpu_issue; only built with CPU_FPU_ISSUE_TIMEOUT_EN.
// o_expired fires in the BUSY cycle that completes TIMEOUT cycles without a result.
module cpu_fpu_issue_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_busy,
  output logic o_expired
);
  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_busy) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = i_busy && (r_count == LIM);

endmodule

// File: rtl/cpu_fpu_issue.sv
// FP issue/retire stage in front of CPU_FPU: holds the request, registers the result.
// Optional watchdog abort under CPU_FPU_ISSUE_TIMEOUT_EN.
module cpu_fpu_issue
  import cpu_fpu_issue_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic           i_clock,
  input  logic           i_reset,
  cpu_fpu_issue_if.slave bus
);
  issue_st_e        r_state;
  issue_st_e        w_next;
  logic [4:0]       r_op;
  logic [31:0]      r_op1;
  logic [31:0]      r_op2;
  logic [31:0]      r_op3;
  logic [TAG_W-1:0] r_rd;
  logic             r_int_dst;
  logic [31:0]      r_result;
  logic [TAG_W-1:0] r_res_rd;
  logic             r_res_int;
  logic             w_accept;
  logic             w_done;
  logic             w_expired;

  assign w_accept = (r_state == IDLE) && bus.i_valid && !bus.i_flush;
  assign w_done   = (r_state == BUSY) && !bus.i_flush
                 && (bus.i_fpu_ready || w_expired);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = BUSY;
      BUSY: begin
        if (bus.i_flush)
          w_next = IDLE;
        else if (bus.i_fpu_ready || w_expired)
          w_next = DONE;
      end
      DONE: if (bus.i_wb_ready || bus.i_flush) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_op3     <= '0;
      r_rd      <= '0;
      r_int_dst <= 1'b0;
      r_result  <= '0;
      r_res_rd  <= '0;
      r_res_int <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op      <= bus.i_op;
        r_op1     <= bus.i_op1;
        r_op2     <= bus.i_op2;
        r_op3     <= bus.i_op3;
        r_rd      <= bus.i_rd;
        r_int_dst <= bus.i_int_dst;
      end
      // A real FPU answer wins over a same-cycle watchdog expiry
      if (w_done) begin
        r_result  <= bus.i_fpu_ready ? bus.i_fpu_result
                                     : FPU_CANON_NAN;
        r_res_rd  <= r_rd;
        r_res_int <= r_int_dst;
      end
    end
  end

`ifdef CPU_FPU_ISSUE_TIMEOUT_EN
  logic r_error;

  cpu_fpu_issue_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_accept),
    .i_busy    (r_state == BUSY),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_error <= 1'b0;
    end else if (w_done) begin
      r_error <= !bus.i_fpu_ready;
    end else if (r_state == DONE && w_next != DONE) begin
      r_error <= 1'b0;
    end
  end

  assign bus.o_error = r_error;
`else
  assign w_expired   = 1'b0;
  assign bus.o_error = 1'b0;
`endif

  assign bus.o_ready       = (r_state == IDLE);
  assign bus.o_fpu_request = (r_state == BUSY);
  assign bus.o_fpu_op      = r_op;
  assign bus.o_fpu_op1     = r_op1;
  assign bus.o_fpu_op2     = r_op2;
  assign bus.o_fpu_op3     = r_op3;
  assign bus.o_valid       = (r_state == DONE);
  assign bus.o_result      = r_result;
  assign bus.o_rd          = r_res_rd;
  assign bus.o_int_dst     = r_res_int;

endmodule

// File: tb/tb_cpu_fpu_issue.sv
// Bench for cpu_fpu_issue with a programmable-latency CPU_FPU stub.
// Vector table plus scoreboard; hand sequences for stall, flush, reset, timeout.
module tb_cpu_fpu_issue;
  import cpu_fpu_issue_pkg::*;

`ifdef CPU_FPU_ISSUE_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  rd;
    logic        idst;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        idst;
    logic        err;
    int          acc;
    int          lat;
    int          reqb;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_bad = 0;
  int   stub_lat = 0;
  int   stub_cnt = 0;
  int   reqhi = 0;
  int   lowrun = 100;
  int   last_gap = 100;
  logic prev_req = 1'b0;
  sb_t  sbq[$];
  vec_t vt[6];

  cpu_fpu_issue_if #(.TAG_W(5)) bus ();

  cpu_fpu_issue #(
    .TAG_W   (5),
    .TIMEOUT (TO)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] s2d(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
    return d;
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [31:0] s;
    logic [10:0] e;
    e = d[62:52] - 11'd896;
    if (d[62:0] == 63'd0) s = {d[63], 31'd0};
    else s = {d[63], e[7:0], d[51:29]};
    return s;
  endfunction

  function automatic logic [31:0] fpu_model(
    input logic [4:0] op, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    real ra, rb;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    if (op == FPU_OP_FADD) r = d2s($realtobits(ra + rb));
    else if (op == FPU_OP_MOV) r = a;
    else if (op == FPU_OP_SGNJ) r = {b[31], a[30:0]};
    else r = a ^ b ^ c;
    return r;
  endfunction

  // CPU_FPU stub: ready after stub_lat request-high cycles
  always @(posedge clk) begin
    if (bus.o_fpu_request) stub_cnt <= stub_cnt + 1;
    else stub_cnt <= 0;
  end
  assign bus.i_fpu_ready  = bus.o_fpu_request && (stub_cnt == stub_lat);
  assign bus.i_fpu_result = fpu_model(bus.o_fpu_op, bus.o_fpu_op1,
                                      bus.o_fpu_op2, bus.o_fpu_op3);

  always @(negedge clk) begin
    prev_req <= bus.o_fpu_request;
    if (bus.o_fpu_request && !prev_req) last_gap <= lowrun;
    if (bus.o_fpu_request) begin
      lowrun <= 0;
      reqhi  <= reqhi + 1;
    end else begin
      lowrun <= lowrun + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    bus.i_valid   = vld;
    bus.i_op      = v.op;
    bus.i_op1     = v.a;
    bus.i_op2     = v.b;
    bus.i_op3     = v.c;
    bus.i_rd      = v.rd;
    bus.i_int_dst = v.idst;
  endtask

  task automatic run_op(input vec_t v, input int hold,
                        input bit chkgap, input bit err);
    sb_t e;
    sb_t g;
    int  k;
    stub_lat = v.lat;
    k = 0;
    while (!bus.o_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(bus.o_ready), 32'd1);
    drive(v, 1'b1);
    bus.i_wb_ready = (hold == 0);
    e.res  = err ? 32'h7FC0_0000 : v.exp;
    e.rd   = v.rd;
    e.idst = v.idst;
    e.err  = err;
    e.acc  = cyc;
    e.lat  = err ? TO + 1 : v.lat + 2;
    e.reqb = reqhi;
    sbq.push_back(e);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk("busy_req", 32'(bus.o_fpu_request), 32'd1);
    chk("busy_rdy", 32'(bus.o_ready), 32'd0);
    chk("busy_op", 32'(bus.o_fpu_op), 32'(v.op));
    chk("busy_op1", bus.o_fpu_op1, v.a);
    chk("busy_op2", bus.o_fpu_op2, v.b);
    chk("busy_op3", bus.o_fpu_op3, v.c);
    k = 0;
    while (!bus.o_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("valid_wait", 32'(bus.o_valid), 32'd1);
    if (bus.o_valid && sbq.size() > 0) begin
      g = sbq.pop_front();
      chk("latency", 32'(cyc - g.acc), 32'(g.lat));
      chk("req_cycles", 32'(reqhi - g.reqb),
          32'(err ? TO : v.lat + 1));
      chk("result", bus.o_result, g.res);
      chk("rd", 32'(bus.o_rd), 32'(g.rd));
      chk("int_dst", 32'(bus.o_int_dst), 32'(g.idst));
      chk("error", 32'(bus.o_error), 32'(g.err));
      if (chkgap) chk("req_gap_ge2", 32'(last_gap >= 2), 32'd1);
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        chk("stall_valid", 32'(bus.o_valid), 32'd1);
        chk("stall_result", bus.o_result, g.res);
        chk("stall_rd", 32'(bus.o_rd), 32'(g.rd));
        chk("stall_rdy", 32'(bus.o_ready), 32'd0);
        chk("stall_req", 32'(bus.o_fpu_request), 32'd0);
      end
    end
    bus.i_wb_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   k;
    int   seen;
    vt[0] = '{FPU_OP_FADD, 32'h3F800000, 32'h40000000, 32'h0,
              5'd7, 1'b0, 4, 32'h40400000};
    vt[1] = '{FPU_OP_MOV, 32'h12345678, 32'h0, 32'h0,
              5'd3, 1'b0, 0, 32'h12345678};
    vt[2] = '{FPU_OP_MOV, 32'hCAFEBABE, 32'h1, 32'h2,
              5'd4, 1'b0, 0, 32'hCAFEBABE};
    vt[3] = '{FPU_OP_SGNJ, 32'h3F800000, 32'h80000000, 32'h0,
              5'd9, 1'b0, 0, 32'hBF800000};
    vt[4] = '{FPU_OP_FADD, 32'h40000000, 32'h40000000, 32'h0,
              5'd31, 1'b0, 1, 32'h40800000};
    vt[5] = '{FPU_OP_CMP_LT, 32'h0000000F, 32'h000000F0, 32'h00000F00,
              5'd1, 1'b1, 3, 32'h00000FFF};

    rst_n = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_op = '0;
    bus.i_op1 = '0;
    bus.i_op2 = '0;
    bus.i_op3 = '0;
    bus.i_rd = '0;
    bus.i_int_dst = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_wb_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_req", 32'(bus.o_fpu_request), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_error", 32'(bus.o_error), 32'd0);
    chk("rst_result", bus.o_result, 32'd0);
    chk("rst_rd", 32'(bus.o_rd), 32'd0);
    chk("rst_int", 32'(bus.o_int_dst), 32'd0);
    chk("rst_op", 32'(bus.o_fpu_op), 32'd0);
    chk("rst_op1", bus.o_fpu_op1, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_op(vt[i], 0, 1'b1, 1'b0);

    // writeback stall for 10 cycles
    run_op(vt[5], 10, 1'b0, 1'b0);

    // flush in IDLE suppresses acceptance
    drive(vt[0], 1'b1);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    chk("idle_flush_rdy", 32'(bus.o_ready), 32'd1);
    chk("idle_flush_req", 32'(bus.o_fpu_request), 32'd0);

    // flush coincident with fpu ready
    stub_lat = 2;
    drive(vt[0], 1'b1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    k = 0;
    while (!bus.i_fpu_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("flush_rdy_seen", 32'(bus.i_fpu_ready), 32'd1);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    chk("flush_idle", 32'(bus.o_ready), 32'd1);
    chk("flush_req", 32'(bus.o_fpu_request), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.o_valid) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", 32'(seen), 32'd0);

    // flush in DONE without writeback
    stub_lat = 0;
    drive(vt[1], 1'b1);
    bus.i_wb_ready = 1'b0;
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("done_before_flush", 32'(bus.o_valid), 32'd1);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    bus.i_wb_ready = 1'b1;
    chk("done_flush_valid", 32'(bus.o_valid), 32'd0);
    chk("done_flush_rdy", 32'(bus.o_ready), 32'd1);

    // reset mid-BUSY
    stub_lat = 8;
    drive(vt[4], 1'b1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_req", 32'(bus.o_fpu_request), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_req", 32'(bus.o_fpu_request), 32'd0);
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_rdy", 32'(bus.o_ready), 32'd1);
    run_op(vt[0], 0, 1'b0, 1'b0);

`ifdef CPU_FPU_ISSUE_TIMEOUT_EN
    v = vt[0];
    v.lat = 1000;
    run_op(v, 0, 1'b0, 1'b1);
    chk("err_cleared", 32'(bus.o_error), 32'd0);
`endif

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
